// File: rtl/mem_defs.sv
// mem_defs: encodings shared by the memory access unit and the control unit's output decode.
package mem_defs;

  // Stack operation select, driven by the control unit alongside a RAM request.
  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_LOAD = 2'b11
  } sp_sel_e;

  // Access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WAIT   = 2'b10,
    ST_DONE   = 2'b11
  } mau_state_e;

  // Width of the read-latency down-counter; it never has to hold more than RD_LATENCY-2.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/stack_ptr_reg.sv
// stack_ptr_reg: 16-bit stack pointer with load/decrement/increment and bounds compares.
// Arithmetic wraps modulo 2^16; load has priority over dec, dec over inc.
module stack_ptr_reg #(
  parameter logic [15:0] SP_RESET    = 16'h0000,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_inc,
  input  logic        i_dec,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  output logic [15:0] o_sp,
  output logic [15:0] o_sp_dec,
  output logic        o_at_limit,
  output logic        o_at_empty
);

  logic [15:0] r_sp;

  // Stack pointer update: load, push-decrement or pop-increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp <= SP_RESET;
    end else if (i_load) begin
      r_sp <= i_load_val;
    end else if (i_dec) begin
      r_sp <= r_sp - 16'd1;
    end else if (i_inc) begin
      r_sp <= r_sp + 16'd1;
    end
  end

  assign o_sp       = r_sp;
  assign o_sp_dec   = r_sp - 16'd1;
  assign o_at_limit = (r_sp == STACK_LIMIT);
  assign o_at_empty = (r_sp == SP_RESET);

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sequences a fixed-latency synchronous RAM for the control unit,
// muxes the access address (PC, bus or stack pointer) and owns the stack pointer.
// Optional build macro: MEM_STACK_BOUNDS_EN enables stack over/underflow detection
// (faulting push/pop skips the RAM and sets a sticky sp_fault).
module mem_access_unit
  import mem_defs::*;
#(
  parameter int unsigned RD_LATENCY  = 2,
  parameter logic [15:0] SP_RESET    = 16'h0000,
  parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic        i_ram_addr_sel,
  input  logic [1:0]  i_sp_sel,
  input  logic [15:0] i_pc_addr,
  input  logic [15:0] i_bus_addr,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_ram_rdata,
  output logic [15:0] o_ram_addr,
  output logic [15:0] o_ram_wdata,
  output logic        o_ram_en,
  output logic        o_ram_we,
  output logic [15:0] o_rdata,
  output logic        o_ready,
  output logic        o_busy,
  output logic [15:0] o_sp,
  output logic        o_sp_fault
);

  localparam int unsigned   CW       = cnt_width(RD_LATENCY);
  localparam logic [CW-1:0] CNT_INIT = (RD_LATENCY >= 2) ? CW'(RD_LATENCY - 2) : '0;

  mau_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_ram_en;
  logic          r_ram_we;
  logic [15:0]   r_ram_addr;
  logic [15:0]   r_ram_wdata;
  logic [15:0]   r_rdata;
  logic          r_ready;
  logic          r_pop_pending;

  sp_sel_e       w_sp_sel;
  logic          w_is_push;
  logic          w_is_pop;
  logic          w_is_load;
  logic          w_accept;
  logic          w_fault;
  logic          w_skip_ram;
  logic          w_write;
  logic [15:0]   w_addr;
  logic [15:0]   w_sp;
  logic [15:0]   w_sp_dec;
  logic          w_at_limit;
  logic          w_at_empty;

  assign w_sp_sel   = sp_sel_e'(i_sp_sel);
  assign w_is_push  = (w_sp_sel == SP_PUSH);
  assign w_is_pop   = (w_sp_sel == SP_POP);
  assign w_is_load  = (w_sp_sel == SP_LOAD);
  assign w_accept   = (r_state == ST_IDLE) && i_req;
  assign w_skip_ram = w_is_load || w_fault;

  // Push/pop force the direction and take their address from the stack pointer.
  assign w_write = w_is_push ? 1'b1 : (w_is_pop ? 1'b0 : i_wr);
  assign w_addr  = w_is_push ? w_sp_dec :
                   w_is_pop  ? w_sp     :
                   (i_ram_addr_sel ? i_bus_addr : i_pc_addr);

  stack_ptr_reg #(
    .SP_RESET    (SP_RESET),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_inc      ((r_state == ST_DONE) && r_pop_pending),
    .i_dec      (w_accept && w_is_push && !w_fault),
    .i_load     (w_accept && w_is_load),
    .i_load_val (i_bus_addr),
    .o_sp       (w_sp),
    .o_sp_dec   (w_sp_dec),
    .o_at_limit (w_at_limit),
    .o_at_empty (w_at_empty)
  );

`ifdef MEM_STACK_BOUNDS_EN
  logic r_sp_fault;

  assign w_fault = w_accept && ((w_is_push && w_at_limit) || (w_is_pop && w_at_empty));

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp_fault <= 1'b0;
    end else if (w_fault) begin
      r_sp_fault <= 1'b1;
    end
  end

  assign o_sp_fault = r_sp_fault;
`else
  logic w_unused_bounds;

  assign w_fault         = 1'b0;
  assign w_unused_bounds = w_at_limit | w_at_empty;
  assign o_sp_fault      = 1'b0;
`endif

  // Access sequencer: IDLE -> ACCESS -> (WAIT) -> DONE -> IDLE with registered RAM strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_ram_en      <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= 16'h0000;
      r_ram_wdata   <= 16'h0000;
      r_rdata       <= 16'h0000;
      r_ready       <= 1'b0;
      r_pop_pending <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (w_skip_ram) begin
              // SP load or faulting stack op: no RAM cycle, complete next cycle.
              r_state       <= ST_DONE;
              r_ready       <= 1'b1;
              r_pop_pending <= 1'b0;
            end else begin
              r_state       <= ST_ACCESS;
              r_ram_en      <= 1'b1;
              r_ram_we      <= w_write;
              r_ram_addr    <= w_addr;
              r_ram_wdata   <= i_wdata;
              r_pop_pending <= w_is_pop;
            end
          end
        end
        ST_ACCESS: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          if (r_ram_we || (RD_LATENCY == 1)) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            if (!r_ram_we) begin
              r_rdata <= i_ram_rdata;
            end
          end else begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_INIT;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
            r_ready <= 1'b1;
            r_rdata <= i_ram_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state       <= ST_IDLE;
          r_ready       <= 1'b0;
          r_pop_pending <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_en    = r_ram_en;
  assign o_ram_we    = r_ram_we;
  assign o_rdata     = r_rdata;
  assign o_ready     = r_ready;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_sp        = w_sp;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table vectors, hand-written corner sequences and a randomized run
// against a transaction-level model of the memory access unit.
module tb_mem_access_unit;

  localparam int unsigned RD_LAT = 2;
  localparam logic [15:0] SP_RST = 16'h0000;
  localparam logic [15:0] SP_LIM = 16'hFF00;
`ifdef MEM_STACK_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, wr, sel;
  logic [1:0]  sp_sel;
  logic [15:0] pc, bus, wdata;
  logic [15:0] ram_rdata, ram_addr, ram_wdata, rdata, sp;
  logic        ram_en, ram_we, ready, busy, sp_fault;

  always #5 clk = ~clk;

  mem_access_unit #(
    .RD_LATENCY  (RD_LAT),
    .SP_RESET    (SP_RST),
    .STACK_LIMIT (SP_LIM)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_wr           (wr),
    .i_ram_addr_sel (sel),
    .i_sp_sel       (sp_sel),
    .i_pc_addr      (pc),
    .i_bus_addr     (bus),
    .i_wdata        (wdata),
    .i_ram_rdata    (ram_rdata),
    .o_ram_addr     (ram_addr),
    .o_ram_wdata    (ram_wdata),
    .o_ram_en       (ram_en),
    .o_ram_we       (ram_we),
    .o_rdata        (rdata),
    .o_ready        (ready),
    .o_busy         (busy),
    .o_sp           (sp),
    .o_sp_fault     (sp_fault)
  );

  // External RAM: one output register, so data is ready at the second edge after the address.
  bit   [15:0] ram [0:65535];
  logic [15:0] rd_q;
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      rd_q <= ram[ram_addr];
    end
  end
  assign ram_rdata = rd_q;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state: stack pointer, sticky fault, last read data, memory image.
  bit [15:0] m_sp;
  bit        m_fault;
  bit [15:0] m_rdata;
  bit [15:0] m_mem [bit [15:0]];

  task automatic model_reset();
    m_sp = SP_RST; m_fault = 1'b0; m_rdata = 16'h0000;
  endtask

  task automatic model(input logic [1:0] s, input logic w, input logic sl,
                       input logic [15:0] pc_i, input logic [15:0] bus_i, input logic [15:0] wd_i,
                       output int e_lat, output int e_en, output logic [15:0] e_addr, output logic e_we);
    e_en = 1; e_addr = sl ? bus_i : pc_i; e_we = w;
    case (s)
      2'b01: if (BOUNDS && m_sp == SP_LIM) begin m_fault = 1'b1; e_en = 0; end
             else begin m_sp = m_sp - 16'd1; e_addr = m_sp; e_we = 1'b1; end
      2'b10: if (BOUNDS && m_sp == SP_RST) begin m_fault = 1'b1; e_en = 0; end
             else begin e_addr = m_sp; e_we = 1'b0; m_sp = m_sp + 16'd1; end
      2'b11: begin m_sp = bus_i; e_en = 0; end
      default: ;
    endcase
    if (e_en == 0) e_lat = 1;
    else if (e_we) begin m_mem[e_addr] = wd_i; e_lat = 2; end
    else begin m_rdata = m_mem.exists(e_addr) ? m_mem[e_addr] : 16'h0000; e_lat = RD_LAT + 1; end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_addr = a; pre_data = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
    m_mem[a] = d;
  endtask

  // Issue one request (single-cycle req) and observe until ready or the cycle budget runs out.
  task automatic exec(input logic [1:0] s, input logic w, input logic sl,
                      input logic [15:0] pc_i, input logic [15:0] bus_i, input logic [15:0] wd_i,
                      output int lat, output int en_cnt, output logic [15:0] a_addr, output logic a_we,
                      output logic [15:0] a_wd, output logic [15:0] a_rd, output logic [15:0] a_sp,
                      output logic a_busy, output logic a_fault);
    lat = -1; en_cnt = 0; a_addr = '0; a_we = 1'b0; a_wd = '0; a_rd = '0;
    sp_sel = s; wr = w; sel = sl; pc = pc_i; bus = bus_i; wdata = wd_i; req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req = 1'b0; sp_sel = 2'($urandom); wr = 1'($urandom); sel = 1'($urandom);
        pc = 16'($urandom); bus = 16'($urandom); wdata = 16'($urandom);
      end
      if (ram_en) begin en_cnt++; a_addr = ram_addr; a_we = ram_we; a_wd = ram_wdata; end
      if (ready) begin lat = k; a_rd = rdata; break; end
    end
    @(negedge clk);
    a_sp = sp; a_busy = busy; a_fault = sp_fault;
  endtask

  task automatic compare_all(input string tag, input int e_lat, input int e_en, input logic [15:0] e_addr,
                             input logic e_we, input logic [15:0] e_wd, input logic [15:0] e_rd,
                             input logic [15:0] e_sp, input logic e_fault,
                             input int lat, input int en_cnt, input logic [15:0] a_addr, input logic a_we,
                             input logic [15:0] a_wd, input logic [15:0] a_rd, input logic [15:0] a_sp,
                             input logic a_busy, input logic a_fault);
    chk({tag, ".latency"}, lat, e_lat);
    chk({tag, ".ram_en_pulses"}, en_cnt, e_en);
    if (e_en != 0) begin
      chk({tag, ".ram_addr"}, a_addr, e_addr);
      chk({tag, ".ram_we"}, a_we, e_we);
      if (e_we) chk({tag, ".ram_wdata"}, a_wd, e_wd);
    end
    chk({tag, ".rdata"}, a_rd, e_rd);
    chk({tag, ".sp"}, a_sp, e_sp);
    chk({tag, ".busy_after"}, a_busy, 1'b0);
    chk({tag, ".sp_fault"}, a_fault, e_fault);
    n_txn++;
    $display("txn %0d %s: op=%0d lat=%0d addr=%h rdata=%h sp=%h fault=%0d",
             n_txn, tag, e_en, lat, a_addr, a_rd, a_sp, a_fault);
  endtask

  task automatic txn_check(input string tag, input logic [1:0] s, input logic w, input logic sl,
                           input logic [15:0] pc_i, input logic [15:0] bus_i, input logic [15:0] wd_i);
    int e_lat, e_en, lat, en_cnt;
    logic [15:0] e_addr, a_addr, a_wd, a_rd, a_sp;
    logic e_we, a_we, a_busy, a_fault;
    model(s, w, sl, pc_i, bus_i, wd_i, e_lat, e_en, e_addr, e_we);
    exec(s, w, sl, pc_i, bus_i, wd_i, lat, en_cnt, a_addr, a_we, a_wd, a_rd, a_sp, a_busy, a_fault);
    compare_all(tag, e_lat, e_en, e_addr, e_we, wd_i, m_rdata, m_sp, m_fault,
                lat, en_cnt, a_addr, a_we, a_wd, a_rd, a_sp, a_busy, a_fault);
  endtask

  typedef struct {
    logic [1:0]  s;
    logic        w, sl;
    logic [15:0] pc_i, bus_i, wd_i;
    int          lat, en;
    logic [15:0] addr;
    logic        we;
    logic [15:0] rd, spv;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int e_lat, e_en, lat, en_cnt, en_seen, rdy_at, rdy_cnt;
    logic [15:0] e_addr, a_addr, a_wd, a_rd, a_sp;
    logic e_we, a_we, a_busy, a_fault, busy4, en5;
    logic [1:0] s;
    logic [15:0] ld;

    //            s     w     sl    pc        bus       wdata     lat en addr      we    rdata     sp
    vecs[0] = '{2'b00, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 3, 1, 16'h0010, 1'b0, 16'hBEEF, 16'h0000};
    vecs[1] = '{2'b00, 1'b1, 1'b1, 16'h0010, 16'h0200, 16'h1234, 2, 1, 16'h0200, 1'b1, 16'hBEEF, 16'h0000};
    vecs[2] = '{2'b00, 1'b0, 1'b1, 16'h0000, 16'h0200, 16'h0000, 3, 1, 16'h0200, 1'b0, 16'h1234, 16'h0000};
    vecs[3] = '{2'b01, 1'b0, 1'b0, 16'h0010, 16'h0200, 16'hAAAA, 2, 1, 16'hFFFF, 1'b1, 16'h1234, 16'hFFFF};
    vecs[4] = '{2'b10, 1'b1, 1'b1, 16'h0010, 16'h0200, 16'h0000, 3, 1, 16'hFFFF, 1'b0, 16'hAAAA, 16'h0000};
    vecs[5] = '{2'b11, 1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0000, 1, 0, 16'h0000, 1'b0, 16'hAAAA, 16'h1234};
    vecs[6] = '{2'b01, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h5555, 2, 1, 16'h1233, 1'b1, 16'hAAAA, 16'h1233};
    vecs[7] = '{2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3, 1, 16'h1233, 1'b0, 16'h5555, 16'h1234};
    vecs[8] = '{2'b00, 1'b1, 1'b0, 16'h0011, 16'h0200, 16'h0F0F, 2, 1, 16'h0011, 1'b1, 16'h5555, 16'h1234};
    vecs[9] = '{2'b00, 1'b0, 1'b0, 16'h0011, 16'h0200, 16'h0000, 3, 1, 16'h0011, 1'b0, 16'h0F0F, 16'h1234};

    rst_n = 1'b0; req = 1'b0; wr = 1'b0; sel = 1'b0; sp_sel = 2'b00;
    pc = '0; bus = '0; wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.ram_en", ram_en, 1'b0);
    chk("reset.ram_we", ram_we, 1'b0);
    chk("reset.ready", ready, 1'b0);
    chk("reset.rdata", rdata, 16'h0000);
    chk("reset.ram_addr", ram_addr, 16'h0000);
    chk("reset.sp", sp, SP_RST);
    chk("reset.sp_fault", sp_fault, 1'b0);
    chk("reset.busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    preload(16'h0010, 16'hBEEF);

    // Directed vectors with hand-computed expectations; the model follows along to stay in sync.
    for (int i = 0; i < 10; i++) begin
      model(vecs[i].s, vecs[i].w, vecs[i].sl, vecs[i].pc_i, vecs[i].bus_i, vecs[i].wd_i, e_lat, e_en, e_addr, e_we);
      exec(vecs[i].s, vecs[i].w, vecs[i].sl, vecs[i].pc_i, vecs[i].bus_i, vecs[i].wd_i,
           lat, en_cnt, a_addr, a_we, a_wd, a_rd, a_sp, a_busy, a_fault);
      compare_all($sformatf("vec%0d", i), vecs[i].lat, vecs[i].en, vecs[i].addr, vecs[i].we, vecs[i].wd_i,
                  vecs[i].rd, vecs[i].spv, 1'b0, lat, en_cnt, a_addr, a_we, a_wd, a_rd, a_sp, a_busy, a_fault);
    end

    // req held through a read and into DONE: exactly one access, the next starts only from IDLE.
    sp_sel = 2'b00; wr = 1'b0; sel = 1'b0; pc = 16'h0010; req = 1'b1;
    en_seen = 0; rdy_at = -1; busy4 = 1'b1; en5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4 && ram_en) en_seen++;
      if (ready && rdy_at < 0) rdy_at = k;
      if (k == 4) busy4 = busy;
      if (k == 5) begin en5 = ram_en; req = 1'b0; end
    end
    chk("held_req.ram_en_pulses", en_seen, 1);
    chk("held_req.ready_cycle", rdy_at, RD_LAT + 1);
    chk("held_req.idle_gap_busy", busy4, 1'b0);
    chk("held_req.second_access_en", en5, 1'b1);
    rdy_at = -1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (ready) begin rdy_at = k; break; end
    end
    chk("held_req.second_ready_cycle", rdy_at, RD_LAT + 1);
    chk("held_req.second_rdata", rdata, 16'hBEEF);
    @(negedge clk);
    m_rdata = 16'hBEEF;

    // Randomized transactions against the model.
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 9);
      s = (r <= 4) ? 2'b00 : (r <= 6) ? 2'b01 : (r <= 8) ? 2'b10 : 2'b11;
      case ($urandom_range(0, 4))
        0: ld = SP_LIM;
        1: ld = SP_LIM + 16'd1;
        2: ld = SP_RST;
        3: ld = SP_RST + 16'd1;
        default: ld = 16'($urandom);
      endcase
      txn_check($sformatf("rnd%0d", i), s, 1'($urandom), 1'($urandom),
                {8'h00, 8'($urandom)}, (s == 2'b11) ? ld : {8'h02, 8'($urandom)}, 16'($urandom));
    end

    // Reset during WAIT: outputs drop at once, no ready follows, next read completes normally.
    txn_check("preload_sp", 2'b11, 1'b0, 1'b0, 16'h0000, 16'h4321, 16'h0000);
    sp_sel = 2'b00; wr = 1'b0; sel = 1'b0; pc = 16'h0010; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("rst_wait.busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_wait.ram_en", ram_en, 1'b0);
    chk("rst_wait.busy", busy, 1'b0);
    chk("rst_wait.sp", sp, SP_RST);
    chk("rst_wait.rdata", rdata, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
    end
    chk("rst_wait.no_ready", rdy_cnt, 0);
    txn_check("rst_wait.next_read", 2'b00, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000);

    // Pop from an empty stack (sp at its reset value).
    preload(16'h0000, 16'h0000);
    txn_check("pop_empty", 2'b10, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
`ifdef MEM_STACK_BOUNDS_EN
    chk("pop_empty.fault_set", sp_fault, 1'b1);
    txn_check("pop_empty.after_load", 2'b11, 1'b0, 1'b0, 16'h0000, 16'h0005, 16'h0000);
    chk("pop_empty.fault_sticky", sp_fault, 1'b1);
`else
    chk("pop_empty.sp_wrap", sp, 16'h0001);
    chk("pop_empty.rdata", rdata, 16'h0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
